// File: rtl/step_controller_pkg.sv
// step_ctrl_pkg: shared types and defaults for the step controller slice.
// Contents: step_state_t FSM encoding, default counter width and watchdog limit.
// No ports; imported by step_controller_if, step_watchdog and step_controller.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_FAULT = 2'b10
  } step_state_t;

  localparam int STEP_CNT_W_DEF   = 8;
  localparam int STEP_TIMEOUT_DEF = 255;

endpackage

// File: rtl/step_controller_if.sv
// step_controller_if: groups the step/run inputs and the request/status outputs.
// Signals: StepPulse, RunMode, StepAck (to controller); StepReq, Busy, StepCount, Fault (from controller).
// Modports: master = the step controller, slave = the board/processor side driving it.
interface step_controller_if
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W = STEP_CNT_W_DEF
);

  logic             StepPulse;
  logic             RunMode;
  logic             StepAck;
  logic             StepReq;
  logic             Busy;
  logic [CNT_W-1:0] StepCount;
  logic             Fault;

  modport master (
    input  StepPulse, RunMode, StepAck,
    output StepReq, Busy, StepCount, Fault
  );

  modport slave (
    output StepPulse, RunMode, StepAck,
    input  StepReq, Busy, StepCount, Fault
  );

endinterface

// File: rtl/step_controller_watchdog.sv
// step_watchdog: counts consecutive cycles with Arm high and flags the cycle the limit is hit.
// Ports: Clk, Reset (sync, active-high), Arm (controller is in S_REQ), Expired (combinational flag).
// Expired is high during the TIMEOUT-th armed cycle so the owner can leave on that edge.
module step_watchdog
  import step_ctrl_pkg::*;
#(
  parameter int TIMEOUT = STEP_TIMEOUT_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Arm,
  output logic Expired
);

  // timer_q holds the number of armed cycles already completed, so the
  // current armed cycle is number timer_q+1; it expires when that equals TIMEOUT.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] timer_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      timer_q <= '0;
    end else if (!Arm) begin
      // Held at zero outside S_REQ, which is the same as clearing on entry.
      timer_q <= '0;
    end else if (timer_q != 16'hFFFF) begin
      timer_q <= timer_q + 16'd1;
    end
  end

  assign Expired = Arm && (timer_q == LIMIT);

endmodule

// File: rtl/step_controller.sv
// step_controller: turns step pulses / run mode into a one-at-a-time StepReq/StepAck handshake.
// Ports: Clk, Reset (sync, active-high), bus (step_controller_if.master: inputs StepPulse,
// RunMode, StepAck; outputs StepReq, Busy, StepCount, Fault). Optional watchdog: STEP_WATCHDOG_EN.
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int CNT_W   = STEP_CNT_W_DEF,
  parameter int TIMEOUT = STEP_TIMEOUT_DEF
) (
  input  logic                     Clk,
  input  logic                     Reset,
  step_controller_if.master        bus
);

  step_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef STEP_WATCHDOG_EN
  logic expired;

  step_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .Clk     (Clk),
    .Reset   (Reset),
    .Arm     (state_q == S_REQ),
    .Expired (expired)
  );
`else
  // Limit is meaningless without the watchdog; keep it referenced.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // StepAck here is a stale ack (e.g. after a reset mid-request): ignored.
          if (bus.StepPulse || bus.RunMode) begin
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          // Pulses are not queued; an ack always wins over watchdog expiry.
          if (bus.StepAck) begin
            state_q <= S_IDLE;
            cnt_q   <= cnt_q + 1'b1;
          end
`ifdef STEP_WATCHDOG_EN
          else if (expired) begin
            state_q <= S_FAULT;
          end
`endif
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.StepReq   = (state_q == S_REQ);
  assign bus.Busy      = (state_q == S_REQ);
  assign bus.StepCount = cnt_q;
`ifdef STEP_WATCHDOG_EN
  assign bus.Fault     = (state_q == S_FAULT);
`else
  assign bus.Fault     = 1'b0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// tb_step_controller: directed scenarios plus randomized traffic against an in-bench model.
// Two controllers (8-bit and 4-bit counters, TIMEOUT=5) share one stimulus stream.
// Fault behaviour is exercised only when STEP_WATCHDOG_EN is defined.
module tb_step_controller;
  import step_ctrl_pkg::*;

  localparam int TMO = 5;
`ifdef STEP_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst   = 1'b1;
  logic pulse = 1'b0;
  logic run   = 1'b0;
  logic ack   = 1'b0;

  step_controller_if #(.CNT_W(8)) bus8 ();
  step_controller_if #(.CNT_W(4)) bus4 ();

  assign bus8.StepPulse = pulse;
  assign bus8.RunMode   = run;
  assign bus8.StepAck   = ack;
  assign bus4.StepPulse = pulse;
  assign bus4.RunMode   = run;
  assign bus4.StepAck   = ack;

  step_controller #(.CNT_W(8), .TIMEOUT(TMO)) dut8 (.Clk(clk), .Reset(rst), .bus(bus8));
  step_controller #(.CNT_W(4), .TIMEOUT(TMO)) dut4 (.Clk(clk), .Reset(rst), .bus(bus4));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: is a request outstanding, has the watchdog tripped,
  // how many steps completed (unbounded), how long the current request has waited.
  bit m_req   = 1'b0;
  bit m_fault = 1'b0;
  int m_cnt   = 0;
  int m_age   = 0;

  int hi_cnt   = 0;
  int rise_cnt = 0;
  bit prev_req = 1'b0;

  always begin
    @(posedge clk);
    if (rst) begin
      m_req = 1'b0; m_fault = 1'b0; m_cnt = 0; m_age = 0;
    end else if (m_fault) begin
      // stuck until reset
    end else if (!m_req) begin
      if (pulse || run) begin
        m_req = 1'b1;
        m_age = 0;
      end
    end else begin
      m_age++;
      if (ack) begin
        m_req = 1'b0;
        m_cnt++;
      end else if (WD && m_age == TMO) begin
        m_req   = 1'b0;
        m_fault = 1'b1;
      end
    end
    #1;
    chk("StepReq8",   32'(bus8.StepReq),   32'(m_req));
    chk("Busy8",      32'(bus8.Busy),      32'(m_req));
    chk("Fault8",     32'(bus8.Fault),     32'(m_fault));
    chk("StepCount8", 32'(bus8.StepCount), 32'(m_cnt % 256));
    chk("StepReq4",   32'(bus4.StepReq),   32'(m_req));
    chk("Fault4",     32'(bus4.Fault),     32'(m_fault));
    chk("StepCount4", 32'(bus4.StepCount), 32'(m_cnt % 16));
    if (bus8.StepReq) hi_cnt++;
    if (bus8.StepReq && !prev_req) rise_cnt++;
    prev_req = bus8.StepReq;
  end

  task automatic cyc(input logic p, input logic r, input logic a);
    pulse = p; run = r; ack = a;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  // Run mode with the processor acking in the second cycle of each request.
  task automatic run_mode(input int ncyc);
    int seen;
    seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      seen = bus8.StepReq ? seen + 1 : 0;
      cyc(0, 1, seen == 2);
    end
  endtask

  initial begin
    int seen;
    bit lvl;
    bit a;

    // Reset state
    do_reset();
    chk("rst_req",   32'(bus8.StepReq),   0);
    chk("rst_busy",  32'(bus8.Busy),      0);
    chk("rst_cnt",   32'(bus8.StepCount), 0);
    chk("rst_fault", 32'(bus8.Fault),     0);

    // 1: single pulse, ack 3 cycles later
    hi_cnt = 0; rise_cnt = 0;
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    chk("t1_req_cycles", 32'(hi_cnt),         3);
    chk("t1_count",      32'(bus8.StepCount), 1);

    // 2: second pulse while busy is dropped
    hi_cnt = 0; rise_cnt = 0;
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    chk("t2_requests", 32'(rise_cnt),        1);
    chk("t2_count",    32'(bus8.StepCount), 2);

    // 3: free run for 30 cycles
    do_reset();
    hi_cnt = 0; rise_cnt = 0;
    run_mode(30);
    cyc(0, 0, 0);
    chk("t3_requests",   32'(rise_cnt),        10);
    chk("t3_req_cycles", 32'(hi_cnt),          20);
    chk("t3_count",      32'(bus8.StepCount), 10);
    chk("t3_idle_after", 32'(bus8.StepReq),    0);

    // 4: 4-bit counter wraps
    do_reset();
    run_mode(48);
    cyc(0, 0, 0);
    chk("t4_cnt4_16", 32'(bus4.StepCount), 0);
    chk("t4_cnt8_16", 32'(bus8.StepCount), 16);
    run_mode(3);
    cyc(0, 0, 0);
    chk("t4_cnt4_17", 32'(bus4.StepCount), 1);
    chk("t4_cnt8_17", 32'(bus8.StepCount), 17);

    // 5: reset mid-request, late ack ignored
    do_reset();
    cyc(1, 0, 0); cyc(0, 0, 0);
    chk("t5_req_before", 32'(bus8.StepReq), 1);
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    chk("t5_req_after",   32'(bus8.StepReq),   0);
    chk("t5_busy_after",  32'(bus8.Busy),      0);
    chk("t5_cnt_after",   32'(bus8.StepCount), 0);
    cyc(0, 0, 1); cyc(0, 0, 0);
    chk("t5_late_ack_cnt", 32'(bus8.StepCount), 0);
    chk("t5_late_ack_req", 32'(bus8.StepReq),   0);

    // 6: watchdog
    do_reset();
`ifdef STEP_WATCHDOG_EN
    hi_cnt = 0;
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    chk("t6_req_cycles", 32'(hi_cnt),       5);
    chk("t6_fault",      32'(bus8.Fault),   1);
    chk("t6_req_low",    32'(bus8.StepReq), 0);
    cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    chk("t6_fault_sticky", 32'(bus8.Fault),     1);
    chk("t6_no_req",       32'(bus8.StepReq),   0);
    chk("t6_cnt_held",     32'(bus8.StepCount), 0);
    do_reset();
    chk("t6_fault_cleared", 32'(bus8.Fault), 0);
    cyc(1, 0, 0);
    repeat (4) cyc(0, 0, 0);
    cyc(0, 0, 1); cyc(0, 0, 0);
    chk("t6_ack_wins_fault", 32'(bus8.Fault),     0);
    chk("t6_ack_wins_cnt",   32'(bus8.StepCount), 1);
`else
    cyc(1, 0, 0);
    repeat (40) cyc(0, 0, 0);
    chk("t6_still_req", 32'(bus8.StepReq), 1);
    chk("t6_no_fault",  32'(bus8.Fault),   0);
    cyc(0, 0, 1); cyc(0, 0, 0);
    chk("t6_cnt",       32'(bus8.StepCount), 1);
`endif

    // Randomized traffic, protocol-compliant acks plus stray acks while idle
    do_reset();
    seen = 0;
    lvl  = 1'b0;
    repeat (3000) begin
      seen = bus8.StepReq ? seen + 1 : 0;
      if ($urandom_range(19) == 0) lvl = ~lvl;
      a = (seen >= 2 && $urandom_range(2) == 0) ||
          (!bus8.StepReq && $urandom_range(7) == 0);
      rst = ($urandom_range(149) == 0);
      cyc($urandom_range(3) == 0, lvl, a);
    end
    rst = 1'b0;
    cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
